// File: rtl/flow_ctrl_fsm.sv
// Flow-control FSM: watches FIFO status flags and drives per-channel pause/continue
// to upstream sources, with resume hysteresis and error-source capture.
module flow_ctrl_fsm #(
  parameter int NUM_FIFO       = 5,
  parameter int NUM_CTRL       = 4,
  parameter int RESUME_DLY     = 3,
  parameter int PER_CHAN_PAUSE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                clear_err,
  input  logic [NUM_FIFO-1:0] almost_full,
  input  logic [NUM_FIFO-1:0] full,
  input  logic [NUM_FIFO-1:0] empty,
  output logic [NUM_CTRL-1:0] pausa,
  output logic [NUM_CTRL-1:0] continuar,
  output logic                idle,
  output logic                error_full,
  output logic [NUM_FIFO-1:0] err_src,
  output logic [7:0]          err_cnt,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_IDLE   = 3'd1,
    S_ACTIVE = 3'd2,
    S_PAUSE  = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [7:0] DLY = 8'(RESUME_DLY);

  state_t              cur_q;
  state_t              nxt;
  logic [7:0]          resume_cnt;
  logic [7:0]          cnt_nxt;
  logic [NUM_CTRL-1:0] ch_latch;
  logic [NUM_CTRL-1:0] ch_latch_nxt;
  logic                ds_latch;
  logic                ds_latch_nxt;
  logic                ds_hit;
  logic [NUM_CTRL-1:0] pause_vec;
  logic [NUM_FIFO-1:0] src_nxt;
  logic                any_full;
  logic                any_af;
  logic                all_empty;

  assign any_full  = |full;
  assign any_af    = |almost_full;
  assign all_empty = &empty;
  assign state     = cur_q;

  // Downstream FIFOs are the indices above the per-channel range.
  always_comb begin
    ds_hit = 1'b0;
    for (int i = NUM_CTRL; i < NUM_FIFO; i++) ds_hit = ds_hit | almost_full[i];
  end

  always_comb begin
    nxt     = cur_q;
    cnt_nxt = 8'd0;
    case (cur_q)
      S_INIT:   if (start) nxt = S_IDLE;
      S_IDLE: begin
        if (any_full)        nxt = S_ERROR;
        else if (!all_empty) nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (any_full)       nxt = S_ERROR;
        else if (any_af)    nxt = S_PAUSE;
        else if (all_empty) nxt = S_IDLE;
      end
      S_PAUSE: begin
        if (any_full)                     nxt = S_ERROR;
        else if (any_af)                  cnt_nxt = 8'd0;
        else if (resume_cnt + 8'd1 == DLY) nxt = S_ACTIVE;
        else                              cnt_nxt = resume_cnt + 8'd1;
      end
      S_ERROR:  if (clear_err && !any_full) nxt = S_IDLE;
      default:  nxt = S_INIT;
    endcase
  end

  // Sticky pause sources live only for the duration of one PAUSE visit.
  always_comb begin
    ch_latch_nxt = '0;
    ds_latch_nxt = 1'b0;
    if (nxt == S_PAUSE) begin
      ch_latch_nxt = ((cur_q == S_PAUSE) ? ch_latch : '0) | almost_full[NUM_CTRL-1:0];
      ds_latch_nxt = ((cur_q == S_PAUSE) && ds_latch) || ds_hit;
    end
    if (PER_CHAN_PAUSE == 0 || ds_latch_nxt) pause_vec = '1;
    else                                     pause_vec = ch_latch_nxt;
    src_nxt = '0;
    if (nxt == S_ERROR) src_nxt = ((cur_q == S_ERROR) ? err_src : '0) | full;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_q      <= S_INIT;
      resume_cnt <= 8'd0;
      ch_latch   <= '0;
      ds_latch   <= 1'b0;
      err_src    <= '0;
      err_cnt    <= 8'd0;
      pausa      <= '0;
      continuar  <= '0;
      idle       <= 1'b0;
      error_full <= 1'b0;
    end else begin
      cur_q      <= nxt;
      resume_cnt <= cnt_nxt;
      ch_latch   <= ch_latch_nxt;
      ds_latch   <= ds_latch_nxt;
      err_src    <= src_nxt;
      if (nxt == S_ERROR && cur_q != S_ERROR && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      idle       <= (nxt == S_IDLE);
      error_full <= (nxt == S_ERROR);
      case (nxt)
        S_IDLE, S_ACTIVE: begin
          pausa     <= '0;
          continuar <= '1;
        end
        S_PAUSE: begin
          pausa     <= pause_vec;
          continuar <= ~pause_vec;
        end
        S_ERROR: begin
          pausa     <= '1;
          continuar <= '0;
        end
        default: begin
          pausa     <= '0;
          continuar <= '0;
        end
      endcase
    end
  end

endmodule
